mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage, between the execute stage and the writeback stage.
- Accepts an instruction from the execute stage over the es/ms valid-allowin handshake.
- For loads whose data-RAM request was already accepted in execute, waits for the data-RAM response, then aligns and extends the returned word.
- Drives the ms-to-ws bus and handshake consumed by the writeback stage; also drives forwarding/stall information to the decode stage.

Parameters:
- ES_TO_MS_BUS_WD, 75, width of the execute-to-memory bus; must equal `ES_TO_MS_BUS_WD.
- MS_TO_WS_BUS_WD, 70, width of the memory-to-writeback bus; must equal `MS_TO_WS_BUS_WD.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- ms_allowin  output  1  stage can accept a new instruction this cycle.
- es_to_ms_valid  input  1  execute stage offers an instruction.
- es_to_ms_bus  input  ES_TO_MS_BUS_WD  {pc[31:0], rf_we, rf_waddr[4:0], alu_result[31:0], ld_en, ld_type[2:0], req_sent}.
- ws_allowin  input  1  writeback can accept.
- ms_to_ws_valid  output  1  result offered to writeback.
- ms_to_ws_bus  output  MS_TO_WS_BUS_WD  {pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
- data_sram_data_ok  input  1  one-cycle pulse; the read/write response for the oldest outstanding request.
- data_sram_rdata  input  32  read data, valid with data_ok.
- ms_valid  output  1  stage holds an instruction.
- ms_rf_waddr  output  5  destination register of the held instruction.
- ms_fwd_blk  output  1  held instruction is a load whose data is not yet available; decode must stall on a hazard.
- ms_fwd_data  output  32  final write data, meaningful when ms_valid && !ms_fwd_blk.

Behaviour:
- Reset (synchronous, active-high): ms_valid=0, bus register=0, data buffer=0, buf_valid=0.
  - Consequently ms_to_ws_valid=0 and ms_fwd_blk=0 after reset.
- Stage registers:
  - ms_valid loads es_to_ms_valid when ms_allowin.
  - The bus register loads es_to_ms_bus when ms_allowin && es_to_ms_valid.
- wait_resp = ld_en && req_sent && !buf_valid.
- ms_ready_go = !wait_resp || data_sram_data_ok.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_to_ws_valid = ms_valid && ms_ready_go.
- Response buffering:
  - If ms_valid && wait_resp && data_sram_data_ok && !ws_allowin, capture data_sram_rdata into the buffer and set buf_valid.
  - Clear buf_valid when the instruction leaves (ms_to_ws_valid && ws_allowin).
- Raw data source:
  - buffer when buf_valid, otherwise data_sram_rdata.
  - data_ok arriving while the stage is not waiting (ms_valid=0, or not a load) is ignored.
- Load alignment on lane alu_result[1:0]; the byte/half is selected from raw word bits [8*lane+7:8*lane].
  - 000 lw: whole word; lane ignored.
  - 001 lb: sign-extended byte.
  - 010 lbu: zero-extended byte.
  - 011 lh: sign-extended half, lane[1] selects the half.
  - 100 lhu: zero-extended half, lane[1] selects the half.
  - Other ld_type codes behave as lw.
- rf_wdata source:
  - ld_en=1: the aligned load data.
  - ld_en=0: alu_result.
- Output bus: ms_to_ws_bus = {pc, rf_we, rf_waddr, rf_wdata}.
- Forwarding and stall outputs:
  - ms_fwd_blk = ms_valid && ld_en && wait_resp && !data_sram_data_ok.
  - ms_fwd_data = rf_wdata.
- Loads with req_sent=0 (request never accepted, e.g. cancelled) pass through without waiting.
  - rf_wdata is then the aligned value of whatever the raw source is; the producer guarantees rf_we=0 in this case.
- A store whose request was sent (ld_en=0) does not wait.
  - Its write response is consumed by the execute-side request logic, not by this stage.
- Back-to-back: a new instruction may enter in the same cycle the previous one leaves.
- Reset asserted while waiting drops the instruction; any later stray data_ok is ignored, since ms_valid=0.

Test Plan:
- ALU instruction pc=0xBFC00000, rf_we=1, waddr=5, alu_result=0x1234, ws_allowin=1 → ms_to_ws_valid=1 next cycle; bus wdata=0x1234; throughput of 1 instruction per cycle over 8 back-to-back instructions.
- lw, req_sent=1, data_ok three cycles after entry with rdata=0xDEADBEEF → ms_to_ws_valid=0 and ms_fwd_blk=1 for 3 cycles, then valid with wdata=0xDEADBEEF; ms_allowin=0 while waiting.
- lb at lane 3, rdata=0x80FF_FFFF → wdata=0xFFFFFF80; lbu at lane 3 → 0x00000080; lh at lane 2, rdata=0x8001_0000 → 0xFFFF8001; lhu → 0x00008001.
- lw gets data_ok=0xCAFEF00D while ws_allowin=0 for 2 cycles → data is buffered; output valid with 0xCAFEF00D once ws_allowin=1; a spurious data_ok during the hold changes nothing.
- Reset pulsed while a load is waiting, then a data_ok arrives → ms_valid=0, no ms_to_ws_valid; the next ALU instruction completes normally.

Source files
------------

// File: rtl/mem_stage_if.sv
// Handshake and bus bundle around the memory stage: execute-side input, writeback-side
// output, data-RAM response and decode-side forwarding information.
interface mem_stage_if #(
  parameter int ES_TO_MS_BUS_WD = 75,
  parameter int MS_TO_WS_BUS_WD = 70
);
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_allowin;
  logic                       ws_allowin;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic                       data_sram_data_ok;
  logic [31:0]                data_sram_rdata;
  logic                       ms_valid;
  logic [4:0]                 ms_rf_waddr;
  logic                       ms_fwd_blk;
  logic [31:0]                ms_fwd_data;

  modport master (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_valid, ms_rf_waddr, ms_fwd_blk,
           ms_fwd_data
  );

  modport slave (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_valid, ms_rf_waddr, ms_fwd_blk,
           ms_fwd_data
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, waits for the data-RAM response of
// a sent load, aligns/extends the loaded word and hands the result to writeback.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 75,
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input logic         clk,
  input logic         reset,
  mem_stage_if.master pipe
);
  logic [ES_TO_MS_BUS_WD-1:0] bus_r;
  logic                       valid_r;
  logic [31:0]                buf_data;
  logic                       buf_valid;

  logic [31:0] pc;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] alu_result;
  logic        ld_en;
  logic [2:0]  ld_type;
  logic        req_sent;

  assign {pc, rf_we, rf_waddr, alu_result, ld_en, ld_type, req_sent} = bus_r;

  logic wait_resp;
  logic ready_go;
  logic allowin;
  logic out_valid;

  assign wait_resp = ld_en && req_sent && !buf_valid;
  assign ready_go  = !wait_resp || pipe.data_sram_data_ok;
  assign allowin   = !valid_r || (ready_go && pipe.ws_allowin);
  assign out_valid = valid_r && ready_go;

  // A response that cannot be handed on this cycle is parked so data_ok never needs repeating.
  logic [31:0] raw;
  assign raw = buf_valid ? buf_data : pipe.data_sram_rdata;

  logic [1:0]  lane;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;

  assign lane = alu_result[1:0];

  always_comb begin
    lane_byte = raw[7:0];
    case (lane)
      2'd0: lane_byte = raw[7:0];
      2'd1: lane_byte = raw[15:8];
      2'd2: lane_byte = raw[23:16];
      2'd3: lane_byte = raw[31:24];
      default: lane_byte = raw[7:0];
    endcase
    lane_half = lane[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    load_data = raw;
    case (ld_type)
      3'b001: load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b010: load_data = {24'd0, lane_byte};
      3'b011: load_data = {{16{lane_half[15]}}, lane_half};
      3'b100: load_data = {16'd0, lane_half};
      default: load_data = raw;
    endcase
  end

  assign rf_wdata = ld_en ? load_data : alu_result;

  logic [MS_TO_WS_BUS_WD-1:0] out_bus;
  assign out_bus = {pc, rf_we, rf_waddr, rf_wdata};

  assign pipe.ms_allowin     = allowin;
  assign pipe.ms_to_ws_valid = out_valid;
  assign pipe.ms_to_ws_bus   = out_bus;
  assign pipe.ms_valid       = valid_r;
  assign pipe.ms_rf_waddr    = rf_waddr;
  assign pipe.ms_fwd_blk     = valid_r && ld_en && wait_resp && !pipe.data_sram_data_ok;
  assign pipe.ms_fwd_data    = rf_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r   <= 1'b0;
      bus_r     <= '0;
      buf_data  <= 32'd0;
      buf_valid <= 1'b0;
    end else begin
      if (allowin) begin
        valid_r <= pipe.es_to_ms_valid;
      end
      if (allowin && pipe.es_to_ms_valid) begin
        bus_r <= pipe.es_to_ms_bus;
      end
      if (valid_r && wait_resp && pipe.data_sram_data_ok && !pipe.ws_allowin) begin
        buf_data  <= pipe.data_sram_rdata;
        buf_valid <= 1'b1;
      end else if (out_valid && pipe.ws_allowin) begin
        buf_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU flow, back-to-back throughput, load wait,
// alignment, response buffering under writeback stall and reset during a wait.
module tb_mem_stage;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_stage_if #(.ES_TO_MS_BUS_WD(75), .MS_TO_WS_BUS_WD(70)) pipe ();

  mem_stage #(.ES_TO_MS_BUS_WD(75), .MS_TO_WS_BUS_WD(70)) dut (
    .clk  (clk),
    .reset(reset),
    .pipe (pipe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [74:0] esBus(input logic [31:0] pc, input logic we,
                                        input logic [4:0] waddr, input logic [31:0] alu,
                                        input logic ld_en, input logic [2:0] ld_type,
                                        input logic req_sent);
    return {pc, we, waddr, alu, ld_en, ld_type, req_sent};
  endfunction

  function automatic logic [69:0] wsBus(input logic [31:0] pc, input logic we,
                                        input logic [4:0] waddr, input logic [31:0] wdata);
    return {pc, we, waddr, wdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [74:0] bus);
    pipe.es_to_ms_valid = valid;
    pipe.es_to_ms_bus   = bus;
  endtask

  task automatic checkOutput(input string tag, input logic [69:0] observed,
                             input logic [69:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One sent load whose response arrives the cycle after entry.
  task automatic loadCase(input string tag, input logic [2:0] ld_type, input logic [31:0] alu,
                          input logic [31:0] rdata, input logic [31:0] expected);
    applyStimulus(1'b1, esBus(32'hBFC01000, 1'b1, 5'd4, alu, 1'b1, ld_type, 1'b1));
    tick();
    applyStimulus(1'b0, '0);
    pipe.data_sram_data_ok = 1'b1;
    pipe.data_sram_rdata   = rdata;
    settle();
    checkOutput({tag, "_valid"}, 70'(pipe.ms_to_ws_valid), 70'd1);
    checkOutput({tag, "_bus"}, pipe.ms_to_ws_bus, wsBus(32'hBFC01000, 1'b1, 5'd4, expected));
    tick();
    pipe.data_sram_data_ok = 1'b0;
    pipe.data_sram_rdata   = 32'd0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    pipe.es_to_ms_valid    = 1'b0;
    pipe.es_to_ms_bus      = '0;
    pipe.ws_allowin        = 1'b1;
    pipe.data_sram_data_ok = 1'b0;
    pipe.data_sram_rdata   = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    settle();
    checkOutput("rst_ms_valid", 70'(pipe.ms_valid), 70'd0);
    checkOutput("rst_out_valid", 70'(pipe.ms_to_ws_valid), 70'd0);
    checkOutput("rst_fwd_blk", 70'(pipe.ms_fwd_blk), 70'd0);
    checkOutput("rst_allowin", 70'(pipe.ms_allowin), 70'd1);
    checkOutput("rst_bus", pipe.ms_to_ws_bus, 70'd0);

    // Single ALU instruction
    applyStimulus(1'b1, esBus(32'hBFC00000, 1'b1, 5'd5, 32'h1234, 1'b0, 3'd0, 1'b0));
    tick();
    applyStimulus(1'b0, '0);
    settle();
    checkOutput("alu_valid", 70'(pipe.ms_to_ws_valid), 70'd1);
    checkOutput("alu_bus", pipe.ms_to_ws_bus, wsBus(32'hBFC00000, 1'b1, 5'd5, 32'h1234));
    checkOutput("alu_waddr", 70'(pipe.ms_rf_waddr), 70'd5);
    checkOutput("alu_fwd_data", 70'(pipe.ms_fwd_data), 70'h1234);
    checkOutput("alu_fwd_blk", 70'(pipe.ms_fwd_blk), 70'd0);
    tick();
    checkOutput("alu_left", 70'(pipe.ms_valid), 70'd0);

    // Eight back-to-back ALU instructions, one per cycle
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, esBus(32'hBFC00000 + 32'(4 * i), 1'b1, 5'(i + 1), 32'h100 + 32'(i),
                                1'b0, 3'd0, 1'b0));
      tick();
      checkOutput($sformatf("b2b%0d_valid", i), 70'(pipe.ms_to_ws_valid), 70'd1);
      checkOutput($sformatf("b2b%0d_bus", i), pipe.ms_to_ws_bus,
                  wsBus(32'hBFC00000 + 32'(4 * i), 1'b1, 5'(i + 1), 32'h100 + 32'(i)));
      checkOutput($sformatf("b2b%0d_allowin", i), 70'(pipe.ms_allowin), 70'd1);
    end
    applyStimulus(1'b0, '0);
    tick();

    // lw waiting three cycles; a younger instruction is held off meanwhile
    applyStimulus(1'b1, esBus(32'hBFC00100, 1'b1, 5'd7, 32'h80000000, 1'b1, 3'd0, 1'b1));
    tick();
    applyStimulus(1'b1, esBus(32'hBFC00200, 1'b1, 5'd9, 32'h5555, 1'b0, 3'd0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      settle();
      checkOutput($sformatf("lw_wait%0d_valid", k), 70'(pipe.ms_to_ws_valid), 70'd0);
      checkOutput($sformatf("lw_wait%0d_blk", k), 70'(pipe.ms_fwd_blk), 70'd1);
      checkOutput($sformatf("lw_wait%0d_allowin", k), 70'(pipe.ms_allowin), 70'd0);
      tick();
    end
    pipe.data_sram_data_ok = 1'b1;
    pipe.data_sram_rdata   = 32'hDEADBEEF;
    settle();
    checkOutput("lw_valid", 70'(pipe.ms_to_ws_valid), 70'd1);
    checkOutput("lw_bus", pipe.ms_to_ws_bus, wsBus(32'hBFC00100, 1'b1, 5'd7, 32'hDEADBEEF));
    checkOutput("lw_blk", 70'(pipe.ms_fwd_blk), 70'd0);
    checkOutput("lw_fwd_data", 70'(pipe.ms_fwd_data), 70'hDEADBEEF);
    checkOutput("lw_allowin", 70'(pipe.ms_allowin), 70'd1);
    tick();
    pipe.data_sram_data_ok = 1'b0;
    pipe.data_sram_rdata   = 32'd0;
    applyStimulus(1'b0, '0);
    settle();
    checkOutput("after_lw_valid", 70'(pipe.ms_to_ws_valid), 70'd1);
    checkOutput("after_lw_bus", pipe.ms_to_ws_bus, wsBus(32'hBFC00200, 1'b1, 5'd9, 32'h5555));
    tick();

    // Alignment and extension
    loadCase("lb_l3", 3'b001, 32'h00001003, 32'h80FFFFFF, 32'hFFFFFF80);
    loadCase("lbu_l3", 3'b010, 32'h00001003, 32'h80FFFFFF, 32'h00000080);
    loadCase("lh_l2", 3'b011, 32'h00001002, 32'h80010000, 32'hFFFF8001);
    loadCase("lhu_l2", 3'b100, 32'h00001002, 32'h80010000, 32'h00008001);
    loadCase("lb_l0", 3'b001, 32'h00001000, 32'h0000007F, 32'h0000007F);
    loadCase("lbu_l1", 3'b010, 32'h00001001, 32'h0000AB00, 32'h000000AB);
    loadCase("lh_l0", 3'b011, 32'h00001000, 32'h1234FF00, 32'hFFFFFF00);
    loadCase("lbu_l2", 3'b010, 32'h00001002, 32'h00C60000, 32'h000000C6);
    loadCase("ldtype5", 3'b101, 32'h00001001, 32'h11223344, 32'h11223344);

    // Load with req_sent=0 passes straight through using the live rdata
    pipe.data_sram_rdata = 32'h000000AA;
    applyStimulus(1'b1, esBus(32'hBFC00400, 1'b0, 5'd2, 32'h00000000, 1'b1, 3'b010, 1'b0));
    tick();
    applyStimulus(1'b0, '0);
    settle();
    checkOutput("nosend_valid", 70'(pipe.ms_to_ws_valid), 70'd1);
    checkOutput("nosend_bus", pipe.ms_to_ws_bus, wsBus(32'hBFC00400, 1'b0, 5'd2, 32'h000000AA));
    tick();
    pipe.data_sram_rdata = 32'd0;

    // Sent store does not wait
    applyStimulus(1'b1, esBus(32'hBFC00500, 1'b0, 5'd0, 32'h00000040, 1'b0, 3'd0, 1'b1));
    tick();
    applyStimulus(1'b0, '0);
    settle();
    checkOutput("store_valid", 70'(pipe.ms_to_ws_valid), 70'd1);
    checkOutput("store_blk", 70'(pipe.ms_fwd_blk), 70'd0);
    tick();

    // Response arrives while writeback stalls: buffered, spurious data_ok ignored
    applyStimulus(1'b1, esBus(32'hBFC00600, 1'b1, 5'd3, 32'h00000000, 1'b1, 3'd0, 1'b1));
    tick();
    applyStimulus(1'b0, '0);
    pipe.ws_allowin        = 1'b0;
    pipe.data_sram_data_ok = 1'b1;
    pipe.data_sram_rdata   = 32'hCAFEF00D;
    settle();
    checkOutput("buf_first_allowin", 70'(pipe.ms_allowin), 70'd0);
    tick();
    pipe.data_sram_data_ok = 1'b0;
    pipe.data_sram_rdata   = 32'd0;
    settle();
    checkOutput("buf_hold_valid", 70'(pipe.ms_to_ws_valid), 70'd1);
    checkOutput("buf_hold_bus", pipe.ms_to_ws_bus, wsBus(32'hBFC00600, 1'b1, 5'd3, 32'hCAFEF00D));
    checkOutput("buf_hold_blk", 70'(pipe.ms_fwd_blk), 70'd0);
    pipe.data_sram_data_ok = 1'b1;
    pipe.data_sram_rdata   = 32'h12345678;
    settle();
    checkOutput("buf_spurious", 70'(pipe.ms_fwd_data), 70'hCAFEF00D);
    tick();
    pipe.data_sram_data_ok = 1'b0;
    pipe.data_sram_rdata   = 32'd0;
    pipe.ws_allowin        = 1'b1;
    settle();
    checkOutput("buf_release_valid", 70'(pipe.ms_to_ws_valid), 70'd1);
    checkOutput("buf_release_bus", pipe.ms_to_ws_bus,
                wsBus(32'hBFC00600, 1'b1, 5'd3, 32'hCAFEF00D));
    checkOutput("buf_release_allowin", 70'(pipe.ms_allowin), 70'd1);
    tick();
    checkOutput("buf_left", 70'(pipe.ms_valid), 70'd0);

    // Next sent load must wait again (buffer cleared on departure)
    applyStimulus(1'b1, esBus(32'hBFC00700, 1'b1, 5'd6, 32'h00000000, 1'b1, 3'd0, 1'b1));
    tick();
    applyStimulus(1'b0, '0);
    settle();
    checkOutput("rewait_blk", 70'(pipe.ms_fwd_blk), 70'd1);

    // Reset while waiting, then a stray data_ok
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pipe.data_sram_data_ok = 1'b1;
    pipe.data_sram_rdata   = 32'h0000FFFF;
    settle();
    checkOutput("rstw_ms_valid", 70'(pipe.ms_valid), 70'd0);
    checkOutput("rstw_out_valid", 70'(pipe.ms_to_ws_valid), 70'd0);
    checkOutput("rstw_blk", 70'(pipe.ms_fwd_blk), 70'd0);
    tick();
    pipe.data_sram_data_ok = 1'b0;
    pipe.data_sram_rdata   = 32'd0;
    applyStimulus(1'b1, esBus(32'hBFC00300, 1'b1, 5'd10, 32'h0000ABCD, 1'b0, 3'd0, 1'b0));
    tick();
    applyStimulus(1'b0, '0);
    settle();
    checkOutput("post_rst_valid", 70'(pipe.ms_to_ws_valid), 70'd1);
    checkOutput("post_rst_bus", pipe.ms_to_ws_bus, wsBus(32'hBFC00300, 1'b1, 5'd10, 32'h0000ABCD));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
